// File: rtl/l2_arbiter_if.sv
// L2 arbiter bus bundle: I-cache port, D-cache port and downstream L2 port.
// master = arbiter side, slave = L1 caches plus L2 memory side.
interface l2_arbiter_if #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
);
   logic              i_read;
   logic              i_write;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_wdata;
   logic [DATA_W-1:0] i_rdata;
   logic              i_ready;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      input  i_read, i_write, i_addr, i_wdata,
      output i_rdata, i_ready,
      input  d_read, d_write, d_addr, d_wdata,
      output d_rdata, d_ready,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      output i_read, i_write, i_addr, i_wdata,
      input  i_rdata, i_ready,
      output d_read, d_write, d_addr, d_wdata,
      input  d_rdata, d_ready,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/l2_arbiter.sv
// Two-port (I/D) L1-to-L2 arbiter: IDLE -> GRANT_x -> RELEASE -> IDLE.
// Fixed D priority by default; `define L2_ARB_RR_EN for round-robin.
module l2_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input  logic         clk,
   input  logic         reset,
   l2_arbiter_if.master bus
);
   typedef enum logic [1:0] {
      IDLE, GRANT_I, GRANT_D, RELEASE
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_ready_q, i_ready_d;
   logic              d_ready_q, d_ready_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              i_req, d_req, pick_d;

   assign i_req = bus.i_read | bus.i_write;
   assign d_req = bus.d_read | bus.d_write;

`ifdef L2_ARB_RR_EN
   // last_q: 1 = D was granted most recently
   logic last_q, last_d;
   assign pick_d = d_req & (~i_req | ~last_q);

   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && (i_req || d_req))
         last_d = pick_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_q <= 1'b0;
      else       last_q <= last_d;
   end
`else
   assign pick_d = d_req;
`endif

   always_comb begin
      state_d     = state_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      unique case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d     = GRANT_D;
               mem_addr_d  = bus.d_addr;
               mem_wdata_d = bus.d_wdata;
               mem_write_d = bus.d_write;
               mem_read_d  = bus.d_read & ~bus.d_write;
            end else if (i_req) begin
               state_d     = GRANT_I;
               mem_addr_d  = bus.i_addr;
               mem_wdata_d = bus.i_wdata;
               mem_write_d = bus.i_write;
               mem_read_d  = bus.i_read & ~bus.i_write;
            end
         end
         GRANT_I: begin
            if (bus.mem_ready) begin
               if (mem_read_q) i_rdata_d = bus.mem_rdata;
               i_ready_d   = 1'b1;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = RELEASE;
            end
         end
         GRANT_D: begin
            if (bus.mem_ready) begin
               if (mem_read_q) d_rdata_d = bus.mem_rdata;
               d_ready_d   = 1'b1;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.i_ready   = i_ready_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter.
// Expected grant order follows L2_ARB_RR_EN when it is defined.
module tb_l2_arbiter;
   localparam int AW = 28;
   localparam int DW = 128;
   localparam logic [DW-1:0] PAT_A5 = {16{8'hA5}};
   localparam logic [DW-1:0] PAT_5A = {16{8'h5A}};
   localparam logic [DW-1:0] PAT_3C = {16{8'h3C}};
   localparam logic [DW-1:0] PAT_77 = {16{8'h77}};
   localparam logic [DW-1:0] WD_D =
      128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;

   logic clk = 1'b0;
   logic reset;
   int   pass_cnt = 0;
   int   total = 0;

   l2_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   l2_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.i_read = 0; bus.i_write = 0;
      bus.i_addr = '0; bus.i_wdata = '0;
      bus.d_read = 0; bus.d_write = 0;
      bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_rdata = '0; bus.mem_ready = 0;
      tick();
      tick();
      total++;
      if ({bus.mem_read, bus.mem_write,
           bus.i_ready, bus.d_ready} !== 4'b0)
         $display("FAIL reset_strobes: got %b want 0000",
                  {bus.mem_read, bus.mem_write,
                   bus.i_ready, bus.d_ready});
      else pass_cnt++;
      total++;
      if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 ||
          bus.i_rdata !== '0 || bus.d_rdata !== '0)
         $display("FAIL reset_data: addr %h wd %h ir %h dr %h want 0",
                  bus.mem_addr, bus.mem_wdata,
                  bus.i_rdata, bus.d_rdata);
      else pass_cnt++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_i_read();
      bus.i_read = 1; bus.i_addr = 28'h0000010;
      tick();
      total++;
      if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0)
         $display("FAIL i_read_strobe: rd %b wr %b want 1 0",
                  bus.mem_read, bus.mem_write);
      else pass_cnt++;
      total++;
      if (bus.mem_addr !== 28'h0000010)
         $display("FAIL i_read_addr: got %h want 0000010",
                  bus.mem_addr);
      else pass_cnt++;
      tick();
      tick();
      total++;
      if (bus.mem_read !== 1'b1)
         $display("FAIL i_read_hold: got %b want 1", bus.mem_read);
      else pass_cnt++;
      bus.mem_ready = 1; bus.mem_rdata = PAT_A5;
      tick();
      bus.mem_ready = 0; bus.mem_rdata = '0;
      total++;
      if (bus.i_ready !== 1'b1 || bus.i_rdata !== PAT_A5)
         $display("FAIL i_read_done: rdy %b data %h want 1 %h",
                  bus.i_ready, bus.i_rdata, PAT_A5);
      else pass_cnt++;
      total++;
      if (bus.mem_read !== 1'b0 || bus.d_ready !== 1'b0)
         $display("FAIL i_read_drop: mrd %b drdy %b want 0 0",
                  bus.mem_read, bus.d_ready);
      else pass_cnt++;
      bus.i_read = 0;
      tick();
      total++;
      if (bus.i_ready !== 1'b0)
         $display("FAIL i_ready_pulse: got %b want 0", bus.i_ready);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_d_write_priority();
      bus.d_write = 1; bus.d_read = 1;
      bus.d_addr = 28'h0ABCDEF; bus.d_wdata = WD_D;
      bus.i_read = 1; bus.i_addr = 28'h0000020;
      tick();
      total++;
      if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0)
         $display("FAIL d_write_strobe: wr %b rd %b want 1 0",
                  bus.mem_write, bus.mem_read);
      else pass_cnt++;
      total++;
      if (bus.mem_addr !== 28'h0ABCDEF || bus.mem_wdata !== WD_D)
         $display("FAIL d_write_bus: addr %h wd %h want 0abcdef %h",
                  bus.mem_addr, bus.mem_wdata, WD_D);
      else pass_cnt++;
      bus.mem_ready = 1; bus.mem_rdata = {16{8'hEE}};
      tick();
      bus.mem_ready = 0;
      total++;
      if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0)
         $display("FAIL d_write_done: drdy %b irdy %b want 1 0",
                  bus.d_ready, bus.i_ready);
      else pass_cnt++;
      total++;
      if (bus.d_rdata !== '0)
         $display("FAIL d_write_rdata: got %h want 0", bus.d_rdata);
      else pass_cnt++;
      bus.d_write = 0; bus.d_read = 0;
      tick();
      total++;
      if (bus.mem_read !== 1'b0 || bus.d_ready !== 1'b0)
         $display("FAIL release_gap: mrd %b drdy %b want 0 0",
                  bus.mem_read, bus.d_ready);
      else pass_cnt++;
      tick();
      total++;
      if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h0000020)
         $display("FAIL i_after_d: rd %b addr %h want 1 0000020",
                  bus.mem_read, bus.mem_addr);
      else pass_cnt++;
      bus.mem_ready = 1; bus.mem_rdata = PAT_5A;
      tick();
      bus.mem_ready = 0;
      total++;
      if (bus.i_ready !== 1'b1 || bus.i_rdata !== PAT_5A)
         $display("FAIL i_after_d_done: rdy %b data %h want 1 %h",
                  bus.i_ready, bus.i_rdata, PAT_5A);
      else pass_cnt++;
      bus.i_read = 0;
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] exp_addr [4];
`ifdef L2_ARB_RR_EN
      exp_addr = '{28'h200, 28'h100, 28'h200, 28'h100};
`else
      exp_addr = '{28'h200, 28'h200, 28'h200, 28'h200};
`endif
      bus.i_read = 1; bus.i_addr = 28'h100;
      bus.d_read = 1; bus.d_addr = 28'h200;
      for (int t = 0; t < 4; t++) begin
         int w;
         w = 0;
         while (bus.mem_read !== 1'b1 && w < 8) begin
            tick();
            w++;
         end
         total++;
         if (w != ((t == 0) ? 1 : 2))
            $display("FAIL b2b_gap[%0d]: waited %0d want %0d",
                     t, w, (t == 0) ? 1 : 2);
         else pass_cnt++;
         total++;
         if (bus.mem_addr !== exp_addr[t])
            $display("FAIL b2b_grant[%0d]: addr %h want %h",
                     t, bus.mem_addr, exp_addr[t]);
         else pass_cnt++;
         bus.mem_ready = 1; bus.mem_rdata = DW'(t);
         tick();
         bus.mem_ready = 0;
      end
      bus.i_read = 0; bus.d_read = 0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      bus.d_read = 1; bus.d_addr = 28'h300;
      tick();
      tick();
      reset = 1'b1;
      #1;
      total++;
      if (bus.mem_read !== 1'b0 || bus.d_ready !== 1'b0)
         $display("FAIL rst_mid_strobe: mrd %b drdy %b want 0 0",
                  bus.mem_read, bus.d_ready);
      else pass_cnt++;
      total++;
      if (bus.mem_addr !== '0 || bus.i_rdata !== '0 ||
          bus.d_rdata !== '0)
         $display("FAIL rst_mid_data: addr %h ir %h dr %h want 0",
                  bus.mem_addr, bus.i_rdata, bus.d_rdata);
      else pass_cnt++;
      bus.d_read = 0;
      tick();
      reset = 1'b0;
      tick();
      total++;
      if (bus.d_ready !== 1'b0 || bus.mem_read !== 1'b0)
         $display("FAIL rst_mid_after: drdy %b mrd %b want 0 0",
                  bus.d_ready, bus.mem_read);
      else pass_cnt++;
      bus.i_read = 1; bus.i_addr = 28'h40;
      tick();
      total++;
      if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h40)
         $display("FAIL rst_regrant: rd %b addr %h want 1 0000040",
                  bus.mem_read, bus.mem_addr);
      else pass_cnt++;
      bus.mem_ready = 1; bus.mem_rdata = PAT_77;
      tick();
      bus.mem_ready = 0;
      total++;
      if (bus.i_ready !== 1'b1 || bus.i_rdata !== PAT_77)
         $display("FAIL rst_regrant_done: rdy %b data %h want 1 %h",
                  bus.i_ready, bus.i_rdata, PAT_77);
      else pass_cnt++;
      bus.i_read = 0;
      tick();
      tick();
   endtask

   task automatic test_withdraw();
      int lows;
      bus.i_read = 1; bus.i_addr = 28'h50;
      tick();
      total++;
      if (bus.mem_read !== 1'b1)
         $display("FAIL wd_grant: got %b want 1", bus.mem_read);
      else pass_cnt++;
      bus.i_read = 0;
      lows = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (bus.mem_read !== 1'b1) lows++;
      end
      total++;
      if (lows != 0)
         $display("FAIL wd_hold: %0d low cycles want 0", lows);
      else pass_cnt++;
      tick();
      bus.mem_ready = 1; bus.mem_rdata = PAT_3C;
      tick();
      bus.mem_ready = 0;
      total++;
      if (bus.i_ready !== 1'b1 || bus.i_rdata !== PAT_3C)
         $display("FAIL wd_done: rdy %b data %h want 1 %h",
                  bus.i_ready, bus.i_rdata, PAT_3C);
      else pass_cnt++;
      tick();
      total++;
      if (bus.i_ready !== 1'b0)
         $display("FAIL wd_pulse: got %b want 0", bus.i_ready);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_spurious();
      bus.mem_ready = 1; bus.mem_rdata = {16{8'hFF}};
      tick();
      tick();
      total++;
      if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0 ||
          bus.mem_read !== 1'b0)
         $display("FAIL spur_ready: ir %b dr %b mrd %b want 0 0 0",
                  bus.i_ready, bus.d_ready, bus.mem_read);
      else pass_cnt++;
      total++;
      if (bus.i_rdata !== PAT_3C || bus.d_rdata !== '0)
         $display("FAIL spur_rdata: ir %h dr %h want %h 0",
                  bus.i_rdata, bus.d_rdata, PAT_3C);
      else pass_cnt++;
      bus.mem_ready = 0;
      bus.d_read = 1; bus.d_addr = 28'h60;
      tick();
      total++;
      if (bus.mem_read !== 1'b1 || bus.mem_addr !== 28'h60)
         $display("FAIL spur_idle: rd %b addr %h want 1 0000060",
                  bus.mem_read, bus.mem_addr);
      else pass_cnt++;
      bus.mem_ready = 1; bus.mem_rdata = PAT_A5;
      tick();
      bus.mem_ready = 0;
      total++;
      if (bus.d_ready !== 1'b1 || bus.d_rdata !== PAT_A5)
         $display("FAIL spur_d_done: rdy %b data %h want 1 %h",
                  bus.d_ready, bus.d_rdata, PAT_A5);
      else pass_cnt++;
      bus.d_read = 0;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_i_read();
      test_d_write_priority();
      test_back_to_back();
      test_reset_mid();
      test_withdraw();
      test_spurious();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, block address width, in 16-byte lines.
REQ-002 Parameter DATA_W, default 128, line width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_read, i_write  input  1 each  I-cache L1 line read and write requests.
REQ-006 i_addr  input  ADDR_W  I-cache line address.
REQ-007 i_wdata  input  DATA_W  I-cache write line.
REQ-008 i_rdata  output  DATA_W  line returned to the I-cache.
REQ-009 i_ready  output  1  one-cycle completion pulse to the I-cache.
REQ-010 d_read, d_write, d_addr, d_wdata, d_rdata, d_ready  same directions and widths  D-cache L1 port.
REQ-011 mem_read, mem_write  output  1 each  downstream (L2) request strobes.
REQ-012 mem_addr  output  ADDR_W, mem_wdata  output  DATA_W  downstream address and write line.
REQ-013 mem_rdata  input  DATA_W, mem_ready  input  1  downstream read line and completion.

Function
REQ-014 The block SHALL implement states IDLE, GRANT_I, GRANT_D and RELEASE.
REQ-015 In IDLE, a pending request (read|write) on a port SHALL move the block to that port's GRANT state on the next edge.
REQ-016 When both ports request in the same IDLE cycle, fixed priority SHALL apply: D before I (overridable per REQ-029).
REQ-017 On entry to GRANT_x, the block SHALL register mem_addr, mem_wdata, mem_read and mem_write from port x, and hold them stable until mem_ready.
REQ-018 If read and write are both high on the granted port, write SHALL be issued and read ignored.
REQ-019 On mem_ready in GRANT_x: x_rdata SHALL load mem_rdata (for reads only; unchanged for writes), x_ready SHALL pulse high for exactly the next cycle, mem_read/mem_write SHALL drop, and the state SHALL become RELEASE.
REQ-020 RELEASE SHALL last one cycle, ignore all requests, then return to IDLE, giving the requester one cycle to drop its strobe.
REQ-021 Latency: request in IDLE at cycle N -> mem strobe high at N+1; mem_ready at cycle M -> x_ready high at M+1 -> next grant strobe no earlier than M+3.
REQ-022 A request withdrawn during GRANT SHALL NOT abort: the transaction completes and x_ready still pulses.
REQ-023 The ungranted port's ready SHALL stay low and its rdata unchanged throughout.
REQ-024 mem_ready outside GRANT states SHALL be ignored.

Reset
REQ-025 Asserting reset SHALL immediately force state IDLE and clear to 0 the outputs i_rdata, d_rdata, i_ready, d_ready, mem_read, mem_write, mem_addr and mem_wdata, plus the round-robin pointer.
REQ-026 Reset mid-transaction SHALL abandon it with no ready pulse; after release, the first edge evaluates requests from IDLE.
REQ-027 Reset deassertion SHALL take effect synchronously: the first state change occurs on the first clk edge with reset low.

Configuration
REQ-028 Macro L2_ARB_RR_EN selects the arbitration policy.
REQ-029 With L2_ARB_RR_EN defined: on simultaneous requests, the port not most recently granted SHALL win. A one-bit last-grant pointer SHALL update on each grant, with reset value = I (so D wins first).
REQ-030 Without L2_ARB_RR_EN: fixed D priority per REQ-016, and no pointer register exists.

Verification
REQ-031 I-port read, addr 0x0000010, mem_ready three cycles after mem_read, mem_rdata=0xA5...A5 -> mem_read high one cycle after the request, mem_addr=0x0000010; i_rdata=0xA5...A5 and i_ready pulsed for one cycle.
REQ-032 D-port write, addr 0x0ABCDEF, wdata=0x1234...; i_read also high the same cycle -> D granted first, mem_write with mem_wdata=0x1234..., d_ready pulse; then after RELEASE the I read is granted.
REQ-033 Both ports continuously requesting for four transactions -> grants D,D,D,D without the macro; D,I,D,I with L2_ARB_RR_EN.
REQ-034 Reset asserted two cycles into a GRANT_D read -> mem_read low immediately, no d_ready pulse, and all outputs 0; after release, a new I request is granted normally.
REQ-035 i_read dropped one cycle after the grant; mem_ready arrives 5 cycles later -> transaction completes, i_ready pulses, and mem_read stays asserted until mem_ready.
REQ-036 Spurious mem_ready in IDLE with no requests -> no ready pulse, no state change, and rdata unchanged.
